// File: rtl/im_sram_ctrl.sv
// im_sram_ctrl: instruction-memory controller for the external instruction SRAM (Ram2).
// Zero-latency fetch from the PC in READ; writes run a registered
// setup / WE-pulse / hold sequence, so Ram2_WE is never gated by the clock.
// While a write owns the bus, the fetch stage is stalled and InsOut carries NOP_INS.
// Optional build macro: IM_WRITE_VERIFY_EN adds a WR_VERIFY readback cycle and a
// sticky WrErr flag; without it WrErr is tied low.
//
// Handshake: WrReq is a level request held high by the requester until WrAck.
// WrAddr/WrData are captured on the rising edge that leaves READ with WrReq=1;
// WrAck is a one-cycle pulse decoded from state.  After each write, at least one
// READ cycle occurs before a still-asserted WrReq is accepted again.
module im_sram_ctrl #(
    parameter int                DATA_W          = 16,
    parameter int                CPU_ADDR_W      = 16,
    parameter int                RAM_ADDR_W      = 18,
    parameter int                WE_PULSE_CYCLES = 1,
    parameter logic [DATA_W-1:0] NOP_INS         = 16'h0800
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [CPU_ADDR_W-1:0] FetchAddr,
    output logic [DATA_W-1:0]     InsOut,
    output logic                  Stall,
    input  logic                  WrReq,
    input  logic [CPU_ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0]     WrData,
    output logic                  WrAck,
    output logic                  WrErr,
    output logic                  Ram2_EN,
    output logic                  Ram2_OE,
    output logic                  Ram2_WE,
    output logic [RAM_ADDR_W-1:0] Ram2_address,
    inout  wire  [DATA_W-1:0]     Ram2_data,
    output logic [2:0]            DbgState
);

    localparam int CNT_W = (WE_PULSE_CYCLES > 1) ? $clog2(WE_PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WE_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        READ      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_PULSE  = 3'd2,
`ifdef IM_WRITE_VERIFY_EN
        WR_HOLD   = 3'd3,
        WR_VERIFY = 3'd4
`else
        WR_HOLD   = 3'd3
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CPU_ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0]     wr_data_q;

    logic                  drive_bus;
    logic                  use_wr_addr;
    logic                  oe_n;
    logic                  we_n;
    logic                  stall;
    logic                  ack;

    // State and pulse-counter registers; reset drops straight back to READ
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= READ;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the write request only when it is accepted out of READ
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (state_q == READ && WrReq) begin
            wr_addr_q <= WrAddr;
            wr_data_q <= WrData;
        end
    end

    // Next-state logic and per-state bus controls, all decoded from state_q
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drive_bus   = 1'b0;
        use_wr_addr = 1'b0;
        oe_n        = 1'b0;
        we_n        = 1'b1;
        stall       = 1'b0;
        ack         = 1'b0;
        case (state_q)
            READ: begin
                if (WrReq) begin
                    state_d = WR_SETUP;
                end
            end
            WR_SETUP: begin
                stall       = 1'b1;
                drive_bus   = 1'b1;
                use_wr_addr = 1'b1;
                oe_n        = 1'b1;
                state_d     = WR_PULSE;
                cnt_d       = CNT_LOAD;
            end
            WR_PULSE: begin
                stall       = 1'b1;
                drive_bus   = 1'b1;
                use_wr_addr = 1'b1;
                oe_n        = 1'b1;
                we_n        = 1'b0;
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HOLD: begin
                stall       = 1'b1;
                drive_bus   = 1'b1;
                use_wr_addr = 1'b1;
                oe_n        = 1'b1;
`ifdef IM_WRITE_VERIFY_EN
                state_d     = WR_VERIFY;
`else
                ack         = 1'b1;
                state_d     = READ;
`endif
            end
`ifdef IM_WRITE_VERIFY_EN
            WR_VERIFY: begin
                // Bus released and OE asserted so the SRAM drives back the stored word
                stall       = 1'b1;
                use_wr_addr = 1'b1;
                ack         = 1'b1;
                state_d     = READ;
            end
`endif
            default: begin
                state_d = READ;
            end
        endcase
    end

`ifdef IM_WRITE_VERIFY_EN
    logic err_q;

    // Sticky readback-mismatch flag, sampled on the edge that leaves WR_VERIFY
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err_q <= 1'b0;
        end else if (state_q == WR_VERIFY && Ram2_data != wr_data_q) begin
            err_q <= 1'b1;
        end
    end

    assign WrErr = err_q;
`else
    assign WrErr = 1'b0;
`endif

    assign Ram2_EN      = 1'b0;
    assign Ram2_OE      = oe_n;
    assign Ram2_WE      = we_n;
    assign Ram2_address = use_wr_addr ? RAM_ADDR_W'(wr_addr_q) : RAM_ADDR_W'(FetchAddr);
    assign Ram2_data    = drive_bus ? wr_data_q : {DATA_W{1'bz}};
    assign InsOut       = stall ? NOP_INS : Ram2_data;
    assign Stall        = stall;
    assign WrAck        = ack;
    assign DbgState     = state_q;

endmodule

// File: tb/tb_im_sram_ctrl.sv
// Bench for im_sram_ctrl: behavioural SRAM on Ram2, reference memory image,
// expected write waveforms derived from the pulse-width parameter.
module tb_im_sram_ctrl;

    localparam int P = 3;
`ifdef IM_WRITE_VERIFY_EN
    localparam int L = P + 3;
`else
    localparam int L = P + 2;
`endif
    localparam logic [15:0] NOP = 16'h0800;

    logic        Clk;
    logic        Rst;
    logic [15:0] FetchAddr;
    logic [15:0] InsOut;
    logic        Stall;
    logic        WrReq;
    logic [15:0] WrAddr;
    logic [15:0] WrData;
    logic        WrAck;
    logic        WrErr;
    logic        Ram2_EN;
    logic        Ram2_OE;
    logic        Ram2_WE;
    logic [17:0] Ram2_address;
    wire  [15:0] Ram2_data;
    logic [2:0]  DbgState;

    int n_checks;
    int n_errors;
    logic exp_err;

    im_sram_ctrl #(
        .DATA_W(16), .CPU_ADDR_W(16), .RAM_ADDR_W(18),
        .WE_PULSE_CYCLES(P), .NOP_INS(NOP)
    ) u_dut (
        .Clk(Clk), .Rst(Rst), .FetchAddr(FetchAddr), .InsOut(InsOut), .Stall(Stall),
        .WrReq(WrReq), .WrAddr(WrAddr), .WrData(WrData), .WrAck(WrAck), .WrErr(WrErr),
        .Ram2_EN(Ram2_EN), .Ram2_OE(Ram2_OE), .Ram2_WE(Ram2_WE),
        .Ram2_address(Ram2_address), .Ram2_data(Ram2_data), .DbgState(DbgState)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // power-on content of the SRAM
    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0003) return 16'h4901;
        return (a * 16'h9E37) ^ 16'h1234;
    endfunction

    // SRAM model: async read when OE low and WE high, stores on edges seen with WE low
    logic [15:0] mem     [0:65535];
    logic        written [0:65535];
    logic [15:0] stuck_mask;
    logic [15:0] ram_idx;
    logic [15:0] sram_q;
    assign ram_idx   = Ram2_address[15:0];
    assign sram_q    = written[ram_idx] ? mem[ram_idx] : init_val(ram_idx);
    assign Ram2_data = (!Ram2_EN && !Ram2_OE && Ram2_WE) ? sram_q : 16'hzzzz;

    always @(posedge Clk) begin
        if (!Ram2_EN && !Ram2_WE) begin
            mem[ram_idx]     <= Ram2_data & ~stuck_mask;
            written[ram_idx] <= 1'b1;
        end
    end

    // reference memory image
    logic [15:0] ref_mem [int];
    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    // fetch at a given address and check the zero-latency read
    task automatic fetch_check(input logic [15:0] a);
        @(negedge Clk);
        FetchAddr = a;
        #1;
        n_checks++;
        if (InsOut !== ref_read(a)) begin
            n_errors++;
            $display("FAIL fetch_data addr=%h got %h expected %h", a, InsOut, ref_read(a));
        end
        n_checks++;
        if (Ram2_address !== {2'b00, a} || Stall !== 1'b0 || Ram2_OE !== 1'b0 || Ram2_WE !== 1'b1) begin
            n_errors++;
            $display("FAIL fetch_ctrl addr=%h got adr=%h stall=%b oe=%b we=%b expected adr=%h stall=0 oe=0 we=1",
                     a, Ram2_address, Stall, Ram2_OE, Ram2_WE, {2'b00, a});
        end
        n_checks++;
        if (WrErr !== exp_err) begin
            n_errors++;
            $display("FAIL wrerr got %b expected %b", WrErr, exp_err);
        end
    endtask

    // present a write request during a READ cycle; the fetch must still be served
    task automatic start_write(input logic [15:0] a, input logic [15:0] d, input logic [15:0] fa);
        @(negedge Clk);
        WrReq = 1'b1; WrAddr = a; WrData = d; FetchAddr = fa;
        #1;
        n_checks++;
        if (Stall !== 1'b0 || InsOut !== ref_read(fa) || WrAck !== 1'b0) begin
            n_errors++;
            $display("FAIL accept_cycle got stall=%b ins=%h ack=%b expected stall=0 ins=%h ack=0",
                     Stall, InsOut, WrAck, ref_read(fa));
        end
    endtask

    // follow the write sequence cycle by cycle against the expected waveform
    task automatic run_write(input logic [15:0] a, input logic [15:0] d, input bit keep_req);
        int we_low;
        logic exp_we, exp_oe, exp_ack;
        we_low = 0;
        for (int k = 1; k <= L; k++) begin
            @(negedge Clk);
            if (k > 1) begin
                WrAddr = 16'($urandom); WrData = 16'($urandom); FetchAddr = 16'($urandom);
            end
            #1;
            exp_we  = !(k >= 2 && k <= P + 1);
            exp_oe  = (k <= P + 2);
            exp_ack = (k == L);
            n_checks++;
            if (Stall !== 1'b1 || InsOut !== NOP) begin
                n_errors++;
                $display("FAIL wr_stall k=%0d got stall=%b ins=%h expected stall=1 ins=%h", k, Stall, InsOut, NOP);
            end
            n_checks++;
            if (Ram2_WE !== exp_we || Ram2_OE !== exp_oe || WrAck !== exp_ack) begin
                n_errors++;
                $display("FAIL wr_ctrl k=%0d got we=%b oe=%b ack=%b expected we=%b oe=%b ack=%b",
                         k, Ram2_WE, Ram2_OE, WrAck, exp_we, exp_oe, exp_ack);
            end
            n_checks++;
            if (Ram2_address !== {2'b00, a}) begin
                n_errors++;
                $display("FAIL wr_addr k=%0d got %h expected %h", k, Ram2_address, {2'b00, a});
            end
            if (k <= P + 2) begin
                n_checks++;
                if (Ram2_data !== d) begin
                    n_errors++;
                    $display("FAIL wr_data k=%0d got %h expected %h", k, Ram2_data, d);
                end
            end
            if (Ram2_WE === 1'b0) we_low++;
            if (k == L && !keep_req) WrReq = 1'b0;
        end
        n_checks++;
        if (we_low != P) begin
            n_errors++;
            $display("FAIL we_width got %0d expected %0d", we_low, P);
        end
        ref_mem[int'(a)] = d & ~stuck_mask;
`ifdef IM_WRITE_VERIFY_EN
        if ((d & stuck_mask) != 16'h0) exp_err = 1'b1;
`endif
    endtask

    task automatic test_reset;
        Rst = 1'b0; WrReq = 1'b0; WrAddr = '0; WrData = '0; FetchAddr = 16'h0003;
        stuck_mask = 16'h0; exp_err = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        n_checks++;
        if (Ram2_WE !== 1'b1 || Ram2_OE !== 1'b0 || Ram2_EN !== 1'b0 || Stall !== 1'b0 ||
            WrAck !== 1'b0 || WrErr !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl got we=%b oe=%b en=%b stall=%b ack=%b err=%b expected 1 0 0 0 0 0",
                     Ram2_WE, Ram2_OE, Ram2_EN, Stall, WrAck, WrErr);
        end
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        n_checks++;
        if (InsOut !== 16'h4901) begin
            n_errors++;
            $display("FAIL reset_fetch got %h expected 4901", InsOut);
        end
        fetch_check(16'h0003);
    endtask

    task automatic test_single_write;
        start_write(16'h0010, 16'h6301, 16'h0003);
        run_write(16'h0010, 16'h6301, 1'b0);
        fetch_check(16'h0011);
        fetch_check(16'h0010);
    endtask

    task automatic test_random_writes;
        logic [15:0] a, d;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom);
            d = 16'($urandom);
            start_write(a, d, 16'($urandom));
            run_write(a, d, 1'b0);
            repeat ($urandom_range(0, 2)) fetch_check(16'($urandom));
            fetch_check(a);
        end
    endtask

    task automatic test_back_to_back;
        start_write(16'h0020, 16'hAAAA, 16'h0100);
        run_write(16'h0020, 16'hAAAA, 1'b1);
        // the single READ cycle between the two sequences
        start_write(16'h0021, 16'h5555, 16'h0020);
        run_write(16'h0021, 16'h5555, 1'b0);
        fetch_check(16'h0020);
        fetch_check(16'h0021);
    endtask

    task automatic test_reset_mid_pulse;
        start_write(16'h0030, 16'hC3C3, 16'h0031);
        @(negedge Clk);
        @(negedge Clk);
        #1;
        n_checks++;
        if (Ram2_WE !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_inpulse got we=%b expected 0", Ram2_WE);
        end
        Rst = 1'b0;
        exp_err = 1'b0;
        #1;
        n_checks++;
        if (Ram2_WE !== 1'b1 || Ram2_OE !== 1'b0 || Stall !== 1'b0 || WrAck !== 1'b0 ||
            InsOut !== ref_read(16'h0031)) begin
            n_errors++;
            $display("FAIL midrst_async got we=%b oe=%b stall=%b ack=%b ins=%h st=%0d expected 1 0 0 0 %h",
                     Ram2_WE, Ram2_OE, Stall, WrAck, InsOut, DbgState, ref_read(16'h0031));
        end
        WrReq = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            #1;
            n_checks++;
            if (WrAck !== 1'b0 || Stall !== 1'b0) begin
                n_errors++;
                $display("FAIL midrst_after got ack=%b stall=%b expected 0 0", WrAck, Stall);
            end
        end
        // aborted write must not have landed
        fetch_check(16'h0030);
    endtask

    task automatic test_verify;
        stuck_mask = 16'h0001;
        start_write(16'h0040, 16'h0001, 16'h0003);
        run_write(16'h0040, 16'h0001, 1'b0);
        fetch_check(16'h0040);
        stuck_mask = 16'h0000;
        start_write(16'h0041, 16'h1234, 16'h0003);
        run_write(16'h0041, 16'h1234, 1'b0);
        fetch_check(16'h0041);
        @(negedge Clk);
        Rst = 1'b0;
        exp_err = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        fetch_check(16'h0040);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 65536; i++) written[i] = 1'b0;
        test_reset();
        test_single_write();
        test_random_writes();
        test_back_to_back();
        test_reset_mid_pulse();
        test_verify();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/im_sram_ctrl.md
Name: im_sram_ctrl

Overview:
- Parametrised instruction-memory controller for the external instruction SRAM (Ram2).
- Serves single-cycle instruction fetch from the CPU's PC, plus a multi-cycle, glitch-free write path for loading or patching instructions.
- A write uses a real setup/pulse/hold sequence instead of gating WE with the clock.
- Stalls the fetch stage while a write owns the SRAM bus, and inserts a NOP bubble during that time.

Parameters:
- DATA_W, 16, instruction / SRAM data width
- CPU_ADDR_W, 16, width of FetchAddr and WrAddr
- RAM_ADDR_W, 18, SRAM address width; must be >= CPU_ADDR_W; upper bits are zero-filled
- WE_PULSE_CYCLES, 1, cycles Ram2_WE is held low; must be >= 1
- NOP_INS, 16'h0800, value driven on InsOut while stalled

Ports:
- Clk  in  1  system clock; all state changes on the rising edge
- Rst  in  1  asynchronous active-low reset
- FetchAddr  in  CPU_ADDR_W  PC fetch address
- InsOut  out  DATA_W  fetched instruction, or NOP_INS while Stall=1
- Stall  out  1  fetch not served this cycle; the PC must hold
- WrReq  in  1  write request; held high until WrAck
- WrAddr  in  CPU_ADDR_W  write address, sampled on acceptance
- WrData  in  DATA_W  write data, sampled on acceptance
- WrAck  out  1  one-cycle completion pulse (combinational from state)
- WrErr  out  1  sticky readback-mismatch flag (see Optional Feature)
- Ram2_EN  out  1  SRAM chip enable, active-low, tied 0
- Ram2_OE  out  1  SRAM output enable, active-low
- Ram2_WE  out  1  SRAM write enable, active-low
- Ram2_address  out  RAM_ADDR_W  SRAM address
- Ram2_data  inout  DATA_W  SRAM data bus

Behaviour:
- Clock and reset: one clock, Clk; Rst is asynchronous and active-low.
- States: READ, WR_SETUP, WR_PULSE, WR_HOLD, plus WR_VERIFY when the feature is built in. Reset state is READ.
- Reset values: state=READ, pulse counter=0, latched address/data=0, WrErr=0. Outputs are therefore Ram2_WE=1, Ram2_OE=0, Ram2_data=Z, Stall=0, WrAck=0.
- Reset mid-write: returns to READ immediately and asynchronously. WE rises at once and the bus releases at once. No WrAck is issued; the requester must re-request.
- READ state:
  - Ram2_address = zero-extended FetchAddr; OE=0; WE=1; data bus Z.
  - InsOut = Ram2_data combinationally, giving zero-latency fetch. Stall=0.
  - If WrReq=1 at a rising edge: latch WrAddr/WrData and go to WR_SETUP.
- WR_SETUP (1 cycle):
  - Address = latched address; data driven with latched data; OE=1; WE=1.
  - Next state: WR_PULSE, with counter loaded to WE_PULSE_CYCLES-1.
- WR_PULSE:
  - WE=0, with address and data held.
  - Counter decrements each cycle; at 0, go to WR_HOLD.
  - WE is low for exactly WE_PULSE_CYCLES cycles.
- WR_HOLD (1 cycle):
  - WE=1, with address and data still driven.
  - WrAck=1 (unless verify is enabled); next state READ.
- In all write states: Stall=1 and InsOut=NOP_INS.
- WrReq handling:
  - Changes to WrReq, WrAddr or WrData during a write are ignored.
  - WrReq still high in the cycle after WrAck starts a new write, but only after exactly one READ cycle. This guarantees fetch progress.
- Write latency: WE_PULSE_CYCLES+2 cycles from acceptance to WrAck.
- WrReq and a fetch in the same READ cycle: the fetch completes that cycle (Stall=0) and the write starts on the next edge. Writes have priority over subsequent fetches.
- Bus safety: Ram2_data is driven only in write states. WE never toggles combinationally with Clk.

Optional Feature:
- Macro: IM_WRITE_VERIFY_EN.
- Defined:
  - WR_HOLD goes to WR_VERIFY (1 cycle) instead of READ. WrAck moves from WR_HOLD to WR_VERIFY.
  - In WR_VERIFY: OE=0, WE=1, data bus Z, address = latched address.
  - On that edge, Ram2_data is compared with the latched data. A mismatch sets WrErr, which stays set until reset.
  - Write latency becomes WE_PULSE_CYCLES+3. Stall stays 1 through WR_VERIFY.
- Not defined: the WR_VERIFY state is absent and WrErr is tied 0.

Test Plan:
- Reset fetch: Rst low→high, FetchAddr=16'h0003, SRAM model holds 16'h4901 at 0x00003 → InsOut=16'h4901, Stall=0, OE=0, WE=1, data bus Z.
- Single write, WE_PULSE_CYCLES=1: WrReq with WrAddr=16'h0010, WrData=16'h6301 → WE low for exactly 1 cycle with addr 0x00010 stable from setup to hold. WrAck on the 3rd cycle after acceptance. Stall=1 and InsOut=16'h0800 for 3 cycles; a later fetch of 0x0010 returns 16'h6301.
- Pulse width, WE_PULSE_CYCLES=3: same write → WE low for 3 consecutive cycles; WrAck 5 cycles after acceptance.
- Back-to-back: WrReq held high across 2 writes (0x0020←16'hAAAA, then 0x0021←16'h5555) → exactly one READ cycle with Stall=0 between the two write sequences; both words read back correctly.
- Reset mid-pulse: drop Rst during WR_PULSE → WE=1 and data bus Z within the same cycle (asynchronous); no WrAck; state READ after release.
- Verify (macro defined): SRAM model forces bit 0 stuck at 0; write 16'h0001 → WrErr=1 after WR_VERIFY and stays 1 through subsequent good writes until Rst.
